// File: rtl/fb_stream_to_video_if.sv
// Framebuffer pixel stream: start/data/dv forward, ready back.
// Driven by the framebuffer reader, consumed by the video timing block.
interface fb_stream_to_video_if;
  logic        start;
  logic [30:0] data;
  logic        dv;
  logic        ready;

  modport master (
    output start,
    output data,
    output dv,
    input  ready
  );

  modport slave (
    input  start,
    input  data,
    input  dv,
    output ready
  );
endinterface

// File: rtl/fb_stream_to_video.sv
// Framebuffer stream to DVI raster: elastic FIFO, timing generator
// and frame-lock FSM that blanks and resyncs on misalignment.
module fb_stream_to_video #(
  parameter int H_ACTIVE = 640,
  parameter int H_FP     = 16,
  parameter int H_SYNC   = 96,
  parameter int H_BP     = 48,
  parameter int V_ACTIVE = 480,
  parameter int V_FP     = 10,
  parameter int V_SYNC   = 2,
  parameter int V_BP     = 33,
  parameter bit SYNC_POL = 1'b0,
  parameter int FIFO_AW  = 4
) (
  input  logic                 iCLK,
  input  logic                 iRESET,
  fb_stream_to_video_if.slave  fb,
  output logic [7:0]           oRED,
  output logic [7:0]           oGRN,
  output logic [7:0]           oBLU,
  output logic                 oHS,
  output logic                 oVS,
  output logic                 oDE,
  output logic                 oSOF,
  output logic                 oUNDERFLOW,
  output logic                 oRESYNC
);

  localparam int H_TOTAL =
    H_ACTIVE + H_FP + H_SYNC + H_BP;
  localparam int V_TOTAL =
    V_ACTIVE + V_FP + V_SYNC + V_BP;
  localparam int HW = $clog2(H_TOTAL);
  localparam int VW = $clog2(V_TOTAL);
  localparam int DEPTH = 1 << FIFO_AW;
  localparam int CW = FIFO_AW + 1;

  localparam logic [HW-1:0] H_LAST =
    HW'(H_TOTAL - 1);
  localparam logic [VW-1:0] V_LAST =
    VW'(V_TOTAL - 1);
  localparam logic [HW-1:0] H_ACT =
    HW'(H_ACTIVE);
  localparam logic [VW-1:0] V_ACT =
    VW'(V_ACTIVE);
  localparam logic [HW-1:0] HS_BEG =
    HW'(H_ACTIVE + H_FP);
  localparam logic [HW-1:0] HS_END =
    HW'(H_ACTIVE + H_FP + H_SYNC);
  localparam logic [VW-1:0] VS_BEG =
    VW'(V_ACTIVE + V_FP);
  localparam logic [VW-1:0] VS_END =
    VW'(V_ACTIVE + V_FP + V_SYNC);
  localparam logic [CW-1:0] FULL =
    CW'(DEPTH);

  typedef enum logic {
    HUNT,
    LOCK
  } state_t;

  state_t state;
  state_t stateNext;

  logic [24:0]        mem [DEPTH];
  logic [FIFO_AW-1:0] wrPtr;
  logic [FIFO_AW-1:0] rdPtr;
  logic [CW-1:0]      count;
  logic               push;
  logic               pop;
  logic               empty;
  logic               headStart;
  logic [23:0]        headRgb;
  logic               unusedHi;

  logic [HW-1:0] hcnt;
  logic [VW-1:0] vcnt;
  logic          hWrap;
  logic          vWrap;
  logic          active;
  logic          hsAct;
  logic          vsAct;
  logic          origin;

  logic [23:0] rgbNext;
  logic        sofNext;
  logic        ufNext;
  logic        rsNext;

  // FIFO: {start, RGB}; bits [30:24] of the word are dropped
  assign unusedHi  = ^fb.data[30:24];
  assign fb.ready  = (count != FULL) && !iRESET;
  assign push      = fb.dv && fb.ready;
  assign empty     = (count == '0);
  assign headStart = mem[rdPtr][24];
  assign headRgb   = mem[rdPtr][23:0];

  always_ff @(posedge iCLK) begin
    if (push) begin
      mem[wrPtr] <= {fb.start, fb.data[23:0]};
    end
  end

  always_ff @(posedge iCLK or posedge iRESET) begin
    if (iRESET) begin
      wrPtr <= '0;
      rdPtr <= '0;
      count <= '0;
    end else begin
      if (push) begin
        wrPtr <= wrPtr + 1'b1;
      end
      if (pop) begin
        rdPtr <= rdPtr + 1'b1;
      end
      case ({push, pop})
        2'b10:   count <= count + 1'b1;
        2'b01:   count <= count - 1'b1;
        default: count <= count;
      endcase
    end
  end

  // Raster counters free-run; they never stall on the stream
  assign hWrap  = (hcnt == H_LAST);
  assign vWrap  = (vcnt == V_LAST);
  assign active = (hcnt < H_ACT) && (vcnt < V_ACT);
  assign hsAct  = (hcnt >= HS_BEG) && (hcnt < HS_END);
  assign vsAct  = (vcnt >= VS_BEG) && (vcnt < VS_END);
  assign origin = (hcnt == '0) && (vcnt == '0);

  always_ff @(posedge iCLK or posedge iRESET) begin
    if (iRESET) begin
      hcnt <= '0;
      vcnt <= '0;
    end else begin
      hcnt <= hWrap ? '0 : hcnt + 1'b1;
      if (hWrap) begin
        vcnt <= vWrap ? '0 : vcnt + 1'b1;
      end
    end
  end

  always_comb begin
    stateNext = state;
    pop       = 1'b0;
    rgbNext   = '0;
    sofNext   = 1'b0;
    ufNext    = 1'b0;
    rsNext    = 1'b0;
    unique case (state)
      HUNT: begin
        if (!empty) begin
          if (!headStart) begin
            pop = 1'b1;
          end else if (origin) begin
            pop       = 1'b1;
            rgbNext   = headRgb;
            sofNext   = 1'b1;
            stateNext = LOCK;
          end
        end
      end
      LOCK: begin
        // Empty wins over alignment; a lost pixel is not caught up
        if (active) begin
          if (empty) begin
            ufNext = 1'b1;
          end else if (origin != headStart) begin
            rsNext    = 1'b1;
            stateNext = HUNT;
          end else begin
            pop     = 1'b1;
            rgbNext = headRgb;
            sofNext = origin;
          end
        end
      end
      default: stateNext = HUNT;
    endcase
  end

  always_ff @(posedge iCLK or posedge iRESET) begin
    if (iRESET) begin
      state      <= HUNT;
      oDE        <= 1'b0;
      oHS        <= ~SYNC_POL;
      oVS        <= ~SYNC_POL;
      oRED       <= '0;
      oGRN       <= '0;
      oBLU       <= '0;
      oSOF       <= 1'b0;
      oUNDERFLOW <= 1'b0;
      oRESYNC    <= 1'b0;
    end else begin
      state      <= stateNext;
      oDE        <= active;
      oHS        <= hsAct ? SYNC_POL : ~SYNC_POL;
      oVS        <= vsAct ? SYNC_POL : ~SYNC_POL;
      oRED       <= rgbNext[23:16];
      oGRN       <= rgbNext[15:8];
      oBLU       <= rgbNext[7:0];
      oSOF       <= sofNext;
      oUNDERFLOW <= ufNext;
      oRESYNC    <= rsNext;
    end
  end

endmodule

// File: tb/tb_fb_stream_to_video.sv
// Directed bench for fb_stream_to_video with a pixel scoreboard
// and an independent raster timing model.
`timescale 1ns/1ps
module tb_fb_stream_to_video;

  localparam int HA = 4;
  localparam int HF = 1;
  localparam int HS = 2;
  localparam int HB = 1;
  localparam int VA = 3;
  localparam int VF = 1;
  localparam int VS = 1;
  localparam int VB = 1;
  localparam int AW = 2;
  localparam int HT = HA + HF + HS + HB;
  localparam int VT = VA + VF + VS + VB;

  logic clk = 1'b0;
  logic rst = 1'b0;
  always #5 clk = ~clk;

  fb_stream_to_video_if fb ();

  logic [7:0] red;
  logic [7:0] grn;
  logic [7:0] blu;
  logic       hs;
  logic       vs;
  logic       de;
  logic       sof;
  logic       uf;
  logic       rs;

  fb_stream_to_video #(
    .H_ACTIVE (HA),
    .H_FP     (HF),
    .H_SYNC   (HS),
    .H_BP     (HB),
    .V_ACTIVE (VA),
    .V_FP     (VF),
    .V_SYNC   (VS),
    .V_BP     (VB),
    .SYNC_POL (1'b0),
    .FIFO_AW  (AW)
  ) dut (
    .iCLK       (clk),
    .iRESET     (rst),
    .fb         (fb),
    .oRED       (red),
    .oGRN       (grn),
    .oBLU       (blu),
    .oHS        (hs),
    .oVS        (vs),
    .oDE        (de),
    .oSOF       (sof),
    .oUNDERFLOW (uf),
    .oRESYNC    (rs)
  );

  int tests = 0;
  int fails = 0;

  typedef struct {
    logic [23:0] rgb;
    logic        sof;
    logic        uf;
    logic        rs;
  } exp_t;

  exp_t sbQ[$];

  int   hM;
  int   vM;
  logic eDe;
  logic eHs;
  logic eVs;

  task automatic chk(string tag, logic [31:0] obs,
                     logic [31:0] expv);
    tests++;
    assert (obs === expv) else begin
      fails++;
      $error("FAIL %s observed=%0h expected=%0h",
             tag, obs, expv);
    end
  endtask

  function automatic logic [23:0] pix(int f, int i);
    logic [7:0] fb8;
    logic [7:0] ib8;
    fb8 = f[7:0];
    ib8 = i[7:0];
    return {fb8, ib8, ib8 ^ 8'h5A};
  endfunction

  task automatic pushE(logic [23:0] rgb, logic s,
                       logic u, logic r);
    exp_t e;
    e.rgb = rgb;
    e.sof = s;
    e.uf  = u;
    e.rs  = r;
    sbQ.push_back(e);
  endtask

  // Raster reference: active-low syncs, 1-cycle output latency
  always @(posedge clk or posedge rst) begin
    if (rst) begin
      hM  <= 0;
      vM  <= 0;
      eDe <= 1'b0;
      eHs <= 1'b1;
      eVs <= 1'b1;
    end else begin
      eDe <= (hM < HA) && (vM < VA);
      eHs <= !((hM >= HA + HF) && (hM < HA + HF + HS));
      eVs <= !((vM >= VA + VF) && (vM < VA + VF + VS));
      if (hM == HT - 1) begin
        hM <= 0;
        vM <= (vM == VT - 1) ? 0 : vM + 1;
      end else begin
        hM <= hM + 1;
      end
    end
  end

  always @(negedge clk) begin
    if (!rst) begin
      chk("de", de, eDe);
      chk("hs", hs, eHs);
      chk("vs", vs, eVs);
      if (de) begin
        chk("sb_entry", sbQ.size() != 0, 1);
        if (sbQ.size() != 0) begin
          exp_t e;
          e = sbQ.pop_front();
          chk("rgb", {red, grn, blu}, e.rgb);
          chk("sof", sof, e.sof);
          chk("underflow", uf, e.uf);
          chk("resync", rs, e.rs);
        end
      end else begin
        chk("blank_pulses", {sof, uf, rs}, 3'b000);
      end
    end
  end

  task automatic checkReset(string tag);
    chk({tag, "_de"}, de, 0);
    chk({tag, "_rgb"}, {red, grn, blu}, 0);
    chk({tag, "_hs"}, hs, 1);
    chk({tag, "_vs"}, vs, 1);
    chk({tag, "_pulses"}, {sof, uf, rs}, 0);
    chk({tag, "_ready"}, fb.ready, 0);
  endtask

  // Called at a negedge; returns at the negedge after acceptance
  task automatic sendWord(logic s, logic [23:0] rgb);
    int n;
    logic [6:0] junk;
    junk     = 7'($urandom);
    fb.start = s;
    fb.data  = {junk, rgb};
    fb.dv    = 1'b1;
    n = 0;
    while (!fb.ready && n < 200) begin
      @(negedge clk);
      n++;
    end
    chk("accept", fb.ready, 1);
    @(negedge clk);
  endtask

  task automatic waitAt(int h, int v);
    int n;
    n = 0;
    while (!(hM == h && vM == v) && n < 200) begin
      @(negedge clk);
      n++;
    end
    chk("wait_pos", {hM[15:0], vM[15:0]},
        {h[15:0], v[15:0]});
  endtask

  task automatic pushBlank(int n);
    for (int i = 0; i < n; i++) pushE(24'h0, 0, 0, 0);
  endtask

  task automatic normalFrame(int f);
    for (int i = 0; i < 12; i++)
      pushE(pix(f, i), i == 0, 0, 0);
    for (int i = 0; i < 12; i++)
      sendWord(i == 0, pix(f, i));
  endtask

  initial begin
    fb.start = 1'b0;
    fb.data  = '0;
    fb.dv    = 1'b0;
    #2 rst = 1'b1;
    #1 checkReset("por");
    pushBlank(12);
    repeat (3) @(negedge clk);
    rst = 1'b0;
    #1 chk("ready_release", fb.ready, 1);
    repeat (2) @(negedge clk);

    normalFrame(1);
    normalFrame(2);
    normalFrame(3);

    // Line 1 of frame 4 starves; its words are never sent
    for (int i = 0; i < 4; i++)
      pushE(pix(4, i), i == 0, 0, 0);
    pushBlank(0);
    for (int i = 0; i < 4; i++) pushE(24'h0, 0, 1, 0);
    for (int i = 8; i < 12; i++)
      pushE(pix(4, i), 0, 0, 0);
    for (int i = 0; i < 4; i++)
      sendWord(i == 0, pix(4, i));
    fb.dv = 1'b0;
    waitAt(HA, 1);
    for (int i = 8; i < 12; i++)
      sendWord(1'b0, pix(4, i));
    normalFrame(5);

    // Short frame: resync at the twelfth active slot
    for (int i = 0; i < 11; i++)
      pushE(pix(6, i), i == 0, 0, 0);
    pushE(24'h0, 0, 0, 1);
    for (int i = 0; i < 11; i++)
      sendWord(i == 0, pix(6, i));
    normalFrame(7);

    // Long frame: resync at next origin, one blank frame
    for (int i = 0; i < 12; i++)
      pushE(pix(8, i), i == 0, 0, 0);
    pushE(24'h0, 0, 0, 1);
    pushBlank(11);
    for (int i = 0; i < 13; i++)
      sendWord(i == 0, pix(8, i));
    normalFrame(9);

    // Reset mid-line with two words still queued
    for (int i = 0; i < 12; i++)
      pushE(pix(10, i), i == 0, 0, 0);
    for (int i = 0; i < 7; i++)
      sendWord(i == 0, pix(10, i));
    fb.dv = 1'b0;
    waitAt(1, 1);
    #1 rst = 1'b1;
    #1 checkReset("midline");
    sbQ.delete();
    repeat (2) @(negedge clk);
    rst = 1'b0;
    #1 chk("ready_rerelease", fb.ready, 1);
    pushBlank(12);
    repeat (2) @(negedge clk);
    normalFrame(11);
    normalFrame(12);
    fb.dv = 1'b0;

    begin
      int n;
      n = 0;
      while (sbQ.size() != 0 && n < 400) begin
        @(negedge clk);
        n++;
      end
    end
    chk("drain", sbQ.size(), 0);
    repeat (10) @(negedge clk);
    $display("[TB] %0d tests run, %0d failed", tests, fails);
    $finish;
  end

endmodule
